wb_sram_slave: RTL and testbench
================================

// Module: wb_sram_slave
// PURPOSE
// Wishbone classic-cycle slave (responder) bridging the instruction/data cache Wishbone masters to an
// external asynchronous 32-bit SRAM. Decodes its window, sequences SRAM strobes with programmable
// wait states, applies byte lanes, returns single-cycle ack/err. Sits behind the bus arbiter.
// PARAMETERS
// BASE_ADDR   32'h8000_0000  byte base of SRAM window
// ADDR_WIDTH  20             SRAM word-address bits; window = 4<<ADDR_WIDTH bytes (4 MiB)
// READ_WAIT   2              cycles ce_n/oe_n held low before sampling data (>=1)
// WRITE_WAIT  2              cycles we_n held low per write (>=1)
// PORTS
// clk           in   1   clock
// rst           in   1   synchronous reset, active-low
// wb_cyc_i      in   1   bus cycle
// wb_stb_i      in   1   strobe
// wb_we_i       in   1   1=write
// wb_adr_i      in   32  byte address
// wb_dat_i      in   32  write data
// wb_sel_i      in   4   byte lanes
// wb_dat_o      out  32  read data
// wb_ack_o      out  1   transfer done
// wb_err_o      out  1   decode/alignment error
// wb_rty_o      out  1   tied 0
// sram_addr_o   out  ADDR_WIDTH  word address
// sram_dq_o     out  32  write data
// sram_dq_i     in   32  read data
// sram_dq_oe_o  out  1   1=drive dq (top-level tristate)
// sram_ce_n_o   out  1   chip enable
// sram_oe_n_o   out  1   output enable
// sram_we_n_o   out  1   write enable
// sram_be_n_o   out  4   byte enables (~sel)
// BEHAVIOUR
// - Reset (rst==0 at edge): state IDLE; ack/err/rty/dq_oe=0; ce_n/oe_n/we_n=1; be_n=4'hF; addr,dq_o,dat_o=0.
//   Reset mid-op: SRAM strobes deassert at that edge; no ack issued.
// - All outputs registered. Cycle 0 = edge where IDLE samples cyc&stb=1.
// - Decode: hit iff BASE_ADDR <= adr < BASE_ADDR+(4<<ADDR_WIDTH), 32-bit compare, no wrap;
//   addr_o = adr[ADDR_WIDTH+1:2] of (adr-BASE_ADDR). Miss or adr[1:0]!=0 -> ERR.
// - FSM: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, RESP, ERR.
//   IDLE: cyc&stb & error -> ERR; read -> READ; write -> WR_SETUP.
//   READ: ce_n=oe_n=0, be_n=~sel, READ_WAIT cycles (down-counter); dq_i latched to dat_o at last edge -> RESP.
//   WR_SETUP (1 cyc): ce_n=0, dq_oe=1, dq_o=dat_i, be_n=~sel, we_n=1 -> WR_PULSE.
//   WR_PULSE: we_n=0 for WRITE_WAIT cycles -> WR_HOLD.
//   WR_HOLD (1 cyc): we_n=1, dq_oe=1, ce_n=0 -> RESP.
//   RESP: ack=1 one cycle, strobes idle -> IDLE. ERR: err=1 one cycle -> IDLE.
// - Latency: read ack in cycle READ_WAIT+1; write ack in cycle WRITE_WAIT+3; err in cycle 1.
// - Back-to-back: new request sampled in the IDLE cycle after RESP/ERR (1 dead cycle); ack never >1 cycle.
// - wb_sel_i==0 write: full sequence with we_n held 1 (no SRAM change), still acked. Read ignores sel for dat_o.
// - wb_dat_o holds last read data until the next read completes.
// - Abort (cyc=0 while busy): READ/WR_SETUP -> IDLE next edge, no ack; WR_PULSE/WR_HOLD finish
//   through WR_HOLD (SRAM hold time) then IDLE with no ack. Abort in RESP/ERR: ack/err still pulse.
// - Address/data/sel/we captured in IDLE; bus changes mid-transfer ignored.
// - dq_oe and oe_n=0 never both asserted; we_n=0 only when dq_oe=1 and ce_n=0.
// STRUCTURE
// - Add to defines.sv: sram_state_t enum, WB_SEL_ALL=4'hF; localparams stay local.
// - Single module, no sub-module; wait counter width $clog2(max(READ_WAIT,WRITE_WAIT))+1.
// - Tristate buffer on dq lives at top level, not here.
// TESTING (READ_WAIT=2, WRITE_WAIT=2)
// - Write 32'hDEADBEEF, sel=F, adr=8000_0010 -> addr_o=4, we_n low cycles 2-3, ack only in cycle 5.
// - Write 32'h0000AB00 sel=4'b0010 same adr -> be_n=4'b1101; read back -> dat_o=DEADABEF, ack cycle 3.
// - Read adr=8040_0000 (window end) and adr=8000_0012 -> err=1 cycle 1 only, ce_n stays 1, no ack.
// - Drop cyc in cycle 1 of read -> ce_n=1 next edge, no ack; drop in WR_PULSE -> WR_HOLD completes, no ack.
// - Assert rst=0 during WR_PULSE -> next edge we_n=ce_n=1, dq_oe=0, FSM IDLE; following read succeeds.
// - Back-to-back reads, stb held -> acks in cycles 3 and 7, each 1 cycle; sel=0 write acked, SRAM unchanged.

Source files
------------

// File: rtl/wb_sram_slave_pkg.sv
// Shared types and constants for the Wishbone-to-asynchronous-SRAM slave.
//   sram_state_t : FSM encoding (IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, RESP, ERR)
//   WB_SEL_ALL   : all four byte lanes selected; also the idle value of be_n
//   max_int      : sizes the shared wait-state counter
package wb_sram_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_RESP     = 3'd5,
    ST_ERR      = 3'd6
  } sram_state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_sram_slave.sv
// Wishbone classic-cycle slave driving an external asynchronous 32-bit SRAM.
// Decodes a BASE_ADDR window, sequences ce_n/oe_n/we_n with programmable
// wait states and returns a single-cycle ack (or err on decode/alignment
// failure). Every bus and SRAM output is registered.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   wb_cyc_i, wb_stb_i  Wishbone cycle / strobe
//   wb_we_i             1 = write
//   wb_adr_i            byte address
//   wb_dat_i, wb_sel_i  write data, byte lanes
//   wb_dat_o            read data, held until the next read completes
//   wb_ack_o, wb_err_o  one-cycle transfer done / error
//   wb_rty_o            constant 0
//   sram_addr_o         SRAM word address
//   sram_dq_o/_i        SRAM write / read data
//   sram_dq_oe_o        1 = drive dq (the tristate buffer sits in the chip top)
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o  SRAM strobes (active low)
//
// Handshake: a request is taken only in IDLE when cyc & stb are both high.
// Address, data, sel and we are captured at that edge and bus changes after
// it are ignored. ack/err is asserted for exactly one cycle and is followed
// by one IDLE cycle before the next request can be sampled. Dropping cyc
// aborts a transfer without ack, except that a write that has already
// started its we_n pulse always completes through WR_HOLD.
//
// Output timing: outputs are registered from the *current* state, so they
// trail the state register by one cycle. Counting the request edge as
// cycle 0, a read acks in cycle READ_WAIT+1, a write in cycle WRITE_WAIT+3
// and an error in cycle 1. The FSM state is visible as 'state' for probing.
module wb_sram_slave
  import wb_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          ADDR_WIDTH = 20,
  parameter int          READ_WAIT  = 2,
  parameter int          WRITE_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_dq_o,
  input  logic [31:0]           sram_dq_i,
  output logic                  sram_dq_oe_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic [3:0]            sram_be_n_o
);

  localparam int CNT_W = $clog2(max_int(READ_WAIT, WRITE_WAIT)) + 1;
  // 33-bit end of window so a window touching 2^32 cannot wrap to zero.
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

  sram_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic aborted, aborted_next;

  // Request captured in IDLE
  logic                  we_r;
  logic [3:0]            sel_r;
  logic [31:0]           dat_r;
  logic [ADDR_WIDTH-1:0] addr_r;

  // Decode
  logic        req, hit, bad, capture;
  logic [31:0] offset;
  logic        unused_offset_bits;

  assign req    = wb_cyc_i & wb_stb_i;
  assign hit    = ({1'b0, wb_adr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, wb_adr_i} < WIN_END);
  assign bad    = !hit || (wb_adr_i[1:0] != 2'b00);
  assign offset = wb_adr_i - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:ADDR_WIDTH+2], offset[1:0]};
  assign capture = (state == ST_IDLE) && req && !bad;

  assign wb_rty_o = 1'b0;

  // Next-cycle values of the registered outputs
  logic       ack_d, err_d, dq_oe_d, ce_n_d, oe_n_d, we_n_d;
  logic [3:0] be_n_d;

  // Next state
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    aborted_next = aborted;
    unique case (state)
      ST_IDLE: begin
        aborted_next = 1'b0;
        if (req) begin
          if (bad)          state_next = ST_ERR;
          else if (wb_we_i) state_next = ST_WR_SETUP;
          else begin
            state_next = ST_READ;
            cnt_next   = RD_LOAD;
          end
        end
      end
      ST_READ: begin
        if (!wb_cyc_i)      state_next = ST_IDLE;
        else if (cnt == '0) state_next = ST_RESP;
        else                cnt_next   = cnt - 1'b1;
      end
      ST_WR_SETUP: begin
        if (!wb_cyc_i) state_next = ST_IDLE;
        else begin
          state_next = ST_WR_PULSE;
          cnt_next   = WR_LOAD;
        end
      end
      ST_WR_PULSE: begin
        // Once we_n has gone low the pulse runs to full width; an abort is
        // only remembered so that no ack is sent afterwards.
        aborted_next = aborted | !wb_cyc_i;
        if (cnt == '0) state_next = ST_WR_HOLD;
        else           cnt_next   = cnt - 1'b1;
      end
      ST_WR_HOLD: begin
        state_next = (aborted || !wb_cyc_i) ? ST_IDLE : ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode of the current state
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dq_oe_d = 1'b0;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = WB_SEL_ALL;
    unique case (state)
      ST_READ: begin
        if (wb_cyc_i) begin
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
          be_n_d = ~sel_r;
        end
      end
      ST_WR_SETUP: begin
        if (wb_cyc_i) begin
          ce_n_d  = 1'b0;
          dq_oe_d = 1'b1;
          be_n_d  = ~sel_r;
        end
      end
      ST_WR_PULSE: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        be_n_d  = ~sel_r;
        // No lanes selected: run the full sequence but never strobe we_n.
        we_n_d  = (sel_r == 4'h0);
      end
      ST_WR_HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        be_n_d  = ~sel_r;
      end
      ST_RESP: ack_d = 1'b1;
      ST_ERR:  err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      aborted      <= 1'b0;
      we_r         <= 1'b0;
      sel_r        <= '0;
      dat_r        <= '0;
      addr_r       <= '0;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      wb_dat_o     <= '0;
      sram_addr_o  <= '0;
      sram_dq_o    <= '0;
      sram_dq_oe_o <= 1'b0;
      sram_ce_n_o  <= 1'b1;
      sram_oe_n_o  <= 1'b1;
      sram_we_n_o  <= 1'b1;
      sram_be_n_o  <= WB_SEL_ALL;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      aborted <= aborted_next;
      if (capture) begin
        we_r   <= wb_we_i;
        sel_r  <= wb_sel_i;
        addr_r <= offset[ADDR_WIDTH+1:2];
        if (wb_we_i) dat_r <= wb_dat_i;
      end
      wb_ack_o     <= ack_d;
      wb_err_o     <= err_d;
      sram_addr_o  <= addr_r;
      sram_dq_o    <= dat_r;
      sram_dq_oe_o <= dq_oe_d;
      sram_ce_n_o  <= ce_n_d;
      sram_oe_n_o  <= oe_n_d;
      sram_we_n_o  <= we_n_d;
      sram_be_n_o  <= be_n_d;
      // oe_n has been low for READ_WAIT cycles by this edge; it rises here.
      if (state == ST_RESP && !we_r) wb_dat_o <= sram_dq_i;
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave (READ_WAIT = WRITE_WAIT = 2) with a small
// behavioural SRAM model on the pins. Each transaction records per-cycle
// snapshots of the outputs (cycle 0 = request edge) that are compared
// against hand-computed timing.
module tb_wb_sram_slave;
  import wb_sram_slave_pkg::*;

  localparam int NC = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  wb_sram_slave #(
    .BASE_ADDR (32'h8000_0000),
    .ADDR_WIDTH(20),
    .READ_WAIT (2),
    .WRITE_WAIT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .sram_addr_o(sram_addr_o), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model (16 words) ----------------
  logic [31:0] mem [16];
  assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[3:0]] : 32'h0;
  always @(posedge clk) begin
    if (!sram_ce_n_o && !sram_we_n_o) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n_o[b]) mem[sram_addr_o[3:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
    end
  end

  // ---------------- pin protocol monitor ----------------
  int viol = 0;
  always @(negedge clk) begin
    if (sram_dq_oe_o && !sram_oe_n_o) viol++;
    if (!sram_we_n_o && !(sram_dq_oe_o && !sram_ce_n_o)) viol++;
    if (wb_ack_o && wb_err_o) viol++;
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- per-cycle snapshots ----------------
  logic        ack_v [NC];
  logic        err_v [NC];
  logic        ce_v  [NC];
  logic        oe_v  [NC];
  logic        we_v  [NC];
  logic        dqoe_v[NC];
  logic [3:0]  be_v  [NC];
  logic [19:0] addr_v[NC];
  logic [31:0] dq_v  [NC];
  logic [31:0] dat_v [NC];
  int ack_first, ack_cnt, err_first, err_cnt, we_first, we_cnt, oe_first, oe_cnt, ce_cnt;

  task automatic analyze();
    ack_first = -1; ack_cnt = 0; err_first = -1; err_cnt = 0;
    we_first = -1; we_cnt = 0; oe_first = -1; oe_cnt = 0; ce_cnt = 0;
    for (int k = 0; k < NC; k++) begin
      if (ack_v[k]) begin ack_cnt++; if (ack_first < 0) ack_first = k; end
      if (err_v[k]) begin err_cnt++; if (err_first < 0) err_first = k; end
      if (!we_v[k]) begin we_cnt++;  if (we_first < 0)  we_first = k;  end
      if (!oe_v[k]) begin oe_cnt++;  if (oe_first < 0)  oe_first = k;  end
      if (!ce_v[k]) ce_cnt++;
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request, then samples NC cycles. Without 'hold' the master
  // scrambles the bus after cycle 0 and drops cyc/stb when it sees ack/err.
  // drop_at >= 0 drops cyc/stb in that cycle.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int drop_at, input bit hold);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      ack_v[k] = wb_ack_o;    err_v[k] = wb_err_o;
      ce_v[k]  = sram_ce_n_o; oe_v[k]  = sram_oe_n_o; we_v[k] = sram_we_n_o;
      dqoe_v[k] = sram_dq_oe_o; be_v[k] = sram_be_n_o;
      addr_v[k] = sram_addr_o;  dq_v[k] = sram_dq_o; dat_v[k] = wb_dat_o;
      if (k == 0 && !hold) begin
        wb_adr_i = $urandom;
        wb_dat_i = $urandom;
        wb_sel_i = 4'($urandom_range(0, 15));
        wb_we_i  = 1'($urandom_range(0, 1));
      end
      if ((!hold && (wb_ack_o || wb_err_o)) || k == drop_at) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    analyze();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst ack",   32'(wb_ack_o), 32'd0);
    chk("rst err",   32'(wb_err_o), 32'd0);
    chk("rst rty",   32'(wb_rty_o), 32'd0);
    chk("rst dq_oe", 32'(sram_dq_oe_o), 32'd0);
    chk("rst ce_n",  32'(sram_ce_n_o), 32'd1);
    chk("rst oe_n",  32'(sram_oe_n_o), 32'd1);
    chk("rst we_n",  32'(sram_we_n_o), 32'd1);
    chk("rst be_n",  32'(sram_be_n_o), 32'hF);
    chk("rst addr",  32'(sram_addr_o), 32'd0);
    chk("rst dq_o",  sram_dq_o, 32'd0);
    chk("rst dat_o", wb_dat_o, 32'd0);
    chk("rst state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Full-word write
    txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, -1, 1'b0);
    chk("w1 addr c1",  32'(addr_v[1]), 32'd4);
    chk("w1 dq_o c1",  dq_v[1], 32'hDEAD_BEEF);
    chk("w1 dq_oe c1", 32'(dqoe_v[1]), 32'd1);
    chk("w1 we_n c1",  32'(we_v[1]), 32'd1);
    chk("w1 be_n c1",  32'(be_v[1]), 32'h0);
    chk("w1 we first", 32'(we_first), 32'd2);
    chk("w1 we cnt",   32'(we_cnt), 32'd2);
    chk("w1 ack cyc",  32'(ack_first), 32'd5);
    chk("w1 ack cnt",  32'(ack_cnt), 32'd1);
    chk("w1 dq_oe c4", 32'(dqoe_v[4]), 32'd1);
    chk("w1 ce_n c4",  32'(ce_v[4]), 32'd0);
    chk("w1 mem",      mem[4], 32'hDEAD_BEEF);

    // Single-lane write
    txn(1'b1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, -1, 1'b0);
    chk("w2 be_n c2",  32'(be_v[2]), 32'b1101);
    chk("w2 ack cyc",  32'(ack_first), 32'd5);
    chk("w2 mem",      mem[4], 32'hDEAD_ABEF);

    // Read back
    txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, -1, 1'b0);
    chk("r1 ack cyc",  32'(ack_first), 32'd3);
    chk("r1 ack cnt",  32'(ack_cnt), 32'd1);
    chk("r1 dat_o",    dat_v[3], 32'hDEAD_ABEF);
    chk("r1 oe first", 32'(oe_first), 32'd1);
    chk("r1 oe cnt",   32'(oe_cnt), 32'd2);
    chk("r1 we cnt",   32'(we_cnt), 32'd0);

    // Window end: decode miss
    txn(1'b0, 32'h8040_0000, 32'h0, 4'hF, -1, 1'b0);
    chk("e1 err cyc",  32'(err_first), 32'd1);
    chk("e1 err cnt",  32'(err_cnt), 32'd1);
    chk("e1 ack cnt",  32'(ack_cnt), 32'd0);
    chk("e1 ce cnt",   32'(ce_cnt), 32'd0);

    // Misaligned
    txn(1'b0, 32'h8000_0012, 32'h0, 4'hF, -1, 1'b0);
    chk("e2 err cyc",  32'(err_first), 32'd1);
    chk("e2 err cnt",  32'(err_cnt), 32'd1);
    chk("e2 ack cnt",  32'(ack_cnt), 32'd0);
    chk("e2 ce cnt",   32'(ce_cnt), 32'd0);
    chk("e2 dat hold", dat_v[NC-1], 32'hDEAD_ABEF);

    // Just below the window
    txn(1'b1, 32'h7FFF_FFFC, 32'h1, 4'hF, -1, 1'b0);
    chk("e3 err cyc",  32'(err_first), 32'd1);
    chk("e3 ce cnt",   32'(ce_cnt), 32'd0);

    // Last word of the window is a hit
    txn(1'b0, 32'h803F_FFFC, 32'h0, 4'hF, -1, 1'b0);
    chk("top ack cyc", 32'(ack_first), 32'd3);
    chk("top addr",    32'(addr_v[1]), 32'hFFFFF);
    chk("top err cnt", 32'(err_cnt), 32'd0);

    // Read aborted in cycle 1
    txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, 1, 1'b0);
    chk("ra ce_n c1",  32'(ce_v[1]), 32'd0);
    chk("ra ce_n c2",  32'(ce_v[2]), 32'd1);
    chk("ra ack cnt",  32'(ack_cnt), 32'd0);

    // Write aborted in WR_PULSE: pulse and hold still complete
    txn(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 1, 1'b0);
    chk("wa we cnt",   32'(we_cnt), 32'd2);
    chk("wa ce_n c4",  32'(ce_v[4]), 32'd0);
    chk("wa ce_n c5",  32'(ce_v[5]), 32'd1);
    chk("wa ack cnt",  32'(ack_cnt), 32'd0);
    chk("wa mem",      mem[8], 32'h1122_3344);

    // Reset during WR_PULSE
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h8000_0030; wb_dat_i = 32'h5555_AAAA; wb_sel_i = 4'hF;
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("rw we_n c2",  32'(sram_we_n_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rw we_n",     32'(sram_we_n_o), 32'd1);
    chk("rw ce_n",     32'(sram_ce_n_o), 32'd1);
    chk("rw dq_oe",    32'(sram_dq_oe_o), 32'd0);
    chk("rw state",    32'(dut.state), 32'(ST_IDLE));
    chk("rw ack",      32'(wb_ack_o), 32'd0);
    rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    txn(1'b0, 32'h8000_0010, 32'h0, 4'hF, -1, 1'b0);
    chk("rw rd ack",   32'(ack_first), 32'd3);
    chk("rw rd dat",   dat_v[3], 32'hDEAD_ABEF);

    // Back-to-back reads with stb held
    txn(1'b0, 32'h8000_0020, 32'h0, 4'hF, 7, 1'b1);
    chk("bb ack c3",   32'(ack_v[3]), 32'd1);
    chk("bb ack c7",   32'(ack_v[7]), 32'd1);
    chk("bb ack cnt",  32'(ack_cnt), 32'd2);
    chk("bb dat c3",   dat_v[3], 32'h1122_3344);
    chk("bb dat c7",   dat_v[7], 32'h1122_3344);

    // sel == 0 write: acked, no SRAM change
    txn(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, -1, 1'b0);
    chk("s0 ack cyc",  32'(ack_first), 32'd5);
    chk("s0 we cnt",   32'(we_cnt), 32'd0);
    chk("s0 ce cnt",   32'(ce_cnt), 32'd4);
    txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, -1, 1'b0);
    chk("s0 rd dat",   dat_v[3], 32'hDEAD_ABEF);

    chk("pin protocol", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
